// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared types and default sizes for the multi-channel trigger unit
package trigger_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_OFFSET_W = 32;
  localparam int DEF_SEG_W    = 16;
  localparam int DEF_LEN_W    = 32;

  typedef enum logic {
    COMB_OR  = 1'b0,
    COMB_AND = 1'b1
  } comb_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM_PEND   = 3'd1,
    ST_WAIT_INACT = 3'd2,
    ST_ARMED      = 3'd3,
    ST_DELAY      = 3'd4,
    ST_REARM      = 3'd5,
    ST_DONE_WAIT  = 3'd6
  } trig_state_e;

endpackage

// File: rtl/trigger_now_sync.sv
// rtl/trigger_now_sync.sv - two-flop synchroniser for the force-trigger input with a one-cycle rising-edge pulse
module trigger_now_sync (
  input  logic adc_clk,
  input  logic reset_n,
  input  logic trigger_now_i,
  output logic tnow_o
);

  (* ASYNC_REG = "TRUE" *) logic r_meta;
  (* ASYNC_REG = "TRUE" *) logic r_sync;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_meta  <= trigger_now_i;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_pulse <= r_sync & ~r_prev;
    end
  end

  assign tnow_o = r_pulse;

endmodule

// File: rtl/trigger_unit_mc.sv
// rtl/trigger_unit_mc.sv - multi-channel segment-aware trigger unit issuing one capture_go_o per segment
module trigger_unit_mc
  import trigger_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int SEG_W    = DEF_SEG_W,
  parameter int LEN_W    = DEF_LEN_W
) (
  input  logic                adc_clk,
  input  logic                reset_n,
  input  logic [NUM_CH-1:0]   trigger_i,
  input  logic [NUM_CH-1:0]   ch_enable_i,
  input  logic [NUM_CH-1:0]   ch_level_i,
  input  logic                combine_and_i,
  input  logic                trigger_wait_i,
  input  logic                trigger_now_i,
  input  logic                arm_i,
  input  logic                armed_and_ready,
  input  logic [OFFSET_W-1:0] trigger_offset_i,
  input  logic [SEG_W-1:0]    num_segments_i,
  input  logic                capture_done_i,
  output logic                arm_o,
  output logic                capture_active_o,
  output logic                capture_go_o,
  output logic [SEG_W-1:0]    segment_cnt_o,
  output logic [NUM_CH-1:0]   trigger_source_o,
  output logic [LEN_W-1:0]    trigger_length_o
);

  trig_state_e         r_state, w_state_nxt;
  comb_mode_e          w_mode;
  logic [NUM_CH-1:0]   w_act;
  logic                w_comb, w_tnow, w_arm_rise, w_abort;
  logic                w_go, w_trig_start, w_seg_last;
  logic [SEG_W-1:0]    w_seg_goal;
  logic                r_arm_d, r_comb_d, r_go;
  logic [OFFSET_W-1:0] r_delay_cnt;
  logic [SEG_W-1:0]    r_seg_cnt;
  logic [NUM_CH-1:0]   r_src;
  logic [LEN_W-1:0]    r_len;

  trigger_now_sync u_tnow_sync (
    .adc_clk       (adc_clk),
    .reset_n       (reset_n),
    .trigger_now_i (trigger_now_i),
    .tnow_o        (w_tnow)
  );

  assign w_mode = comb_mode_e'(combine_and_i);
  assign w_act  = ~(trigger_i ^ ch_level_i) & ch_enable_i;

  // Disabled channels count as satisfied in AND mode; an empty enable set never triggers.
  always_comb begin
    if (w_mode == COMB_AND) w_comb = (&(w_act | ~ch_enable_i)) & (|ch_enable_i);
    else                    w_comb = |w_act;
  end

  assign w_arm_rise = arm_i & ~r_arm_d;
  assign w_abort    = (r_state != ST_IDLE) && (!arm_i || capture_done_i);
  assign w_seg_goal = (num_segments_i == '0) ? SEG_W'(1) : num_segments_i;
  assign w_seg_last = ({1'b0, r_seg_cnt} + (SEG_W+1)'(1)) >= {1'b0, w_seg_goal};

  always_comb begin
    w_state_nxt  = r_state;
    w_go         = 1'b0;
    w_trig_start = 1'b0;
    case (r_state)
      ST_IDLE:       if (w_arm_rise) w_state_nxt = ST_ARM_PEND;
      ST_ARM_PEND:   if (armed_and_ready) w_state_nxt = trigger_wait_i ? ST_WAIT_INACT : ST_ARMED;
      ST_WAIT_INACT: if (!w_comb) w_state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (w_comb || w_tnow) begin
          w_state_nxt  = ST_DELAY;
          w_trig_start = 1'b1;
        end
      end
      ST_DELAY: begin
        if (r_delay_cnt == trigger_offset_i) begin
          w_go        = 1'b1;
          w_state_nxt = w_seg_last ? ST_DONE_WAIT : ST_REARM;
        end
      end
      // A held trigger must drop before it can start the next segment; tnow skips that.
      ST_REARM:      if (w_tnow || (w_comb && !r_comb_d)) w_state_nxt = ST_DELAY;
      ST_DONE_WAIT:  if (capture_done_i) w_state_nxt = ST_IDLE;
      default:       w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt  = ST_IDLE;
      w_go         = 1'b0;
      w_trig_start = 1'b0;
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_d     <= 1'b0;
      r_comb_d    <= 1'b0;
      r_go        <= 1'b0;
      r_delay_cnt <= '0;
      r_seg_cnt   <= '0;
      r_src       <= '0;
      r_len       <= '0;
    end else begin
      r_arm_d  <= arm_i;
      r_comb_d <= w_comb;
      r_go     <= w_go;
      // Counter only runs while staying in DELAY, so every entry starts from zero.
      r_delay_cnt <= (r_state == ST_DELAY && w_state_nxt == ST_DELAY) ?
                     r_delay_cnt + OFFSET_W'(1) : '0;
      if (w_arm_rise)  r_seg_cnt <= '0;
      else if (w_go)   r_seg_cnt <= r_seg_cnt + SEG_W'(1);
      if (w_trig_start) r_src <= w_act;
      if (w_arm_rise)                 r_len <= '0;
      else if (w_comb && !(&r_len))   r_len <= r_len + LEN_W'(1);
    end
  end

  assign arm_o            = (r_state != ST_IDLE);
  assign capture_active_o = (r_state == ST_DELAY) || (r_state == ST_REARM) ||
                            (r_state == ST_DONE_WAIT);
  assign capture_go_o     = r_go;
  assign segment_cnt_o    = r_seg_cnt;
  assign trigger_source_o = r_src;
  assign trigger_length_o = r_len;

endmodule

// File: tb/tb_trigger_unit_mc.sv
// tb/tb_trigger_unit_mc.sv - self-checking bench for trigger_unit_mc
module tb_trigger_unit_mc;
  localparam int NUM_CH = 4, OFFSET_W = 32, SEG_W = 16, LEN_W = 32;

  logic adc_clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NUM_CH-1:0] trigger_i, ch_enable_i, ch_level_i;
  logic combine_and_i, trigger_wait_i, trigger_now_i, arm_i, armed_and_ready, capture_done_i;
  logic [OFFSET_W-1:0] trigger_offset_i;
  logic [SEG_W-1:0] num_segments_i;
  logic arm_o, capture_active_o, capture_go_o;
  logic [SEG_W-1:0] segment_cnt_o;
  logic [NUM_CH-1:0] trigger_source_o;
  logic [LEN_W-1:0] trigger_length_o;

  int checks = 0;
  int errors = 0;

  always #5 adc_clk = ~adc_clk;

  trigger_unit_mc #(.NUM_CH(NUM_CH), .OFFSET_W(OFFSET_W), .SEG_W(SEG_W), .LEN_W(LEN_W)) dut (
    .adc_clk(adc_clk), .reset_n(reset_n), .trigger_i(trigger_i), .ch_enable_i(ch_enable_i),
    .ch_level_i(ch_level_i), .combine_and_i(combine_and_i), .trigger_wait_i(trigger_wait_i),
    .trigger_now_i(trigger_now_i), .arm_i(arm_i), .armed_and_ready(armed_and_ready),
    .trigger_offset_i(trigger_offset_i), .num_segments_i(num_segments_i),
    .capture_done_i(capture_done_i), .arm_o(arm_o), .capture_active_o(capture_active_o),
    .capture_go_o(capture_go_o), .segment_cnt_o(segment_cnt_o),
    .trigger_source_o(trigger_source_o), .trigger_length_o(trigger_length_o)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge adc_clk);
      #1;
    end
  endtask

  task automatic run_count(input int n, output int go_n, output int first);
    go_n = 0;
    first = -1;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (capture_go_o) begin
        go_n++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic settle();
    arm_i = 1'b0; capture_done_i = 1'b0; trigger_i = '0; trigger_now_i = 1'b0;
    tick(5);
  endtask

  // Reference model: event-oriented view of one arm cycle, evaluated at each clock edge.
  bit m_busy, m_wait_ready, m_need_low, m_started, m_finished, m_go, m_comb_prev, m_arm_prev;
  int m_cd, m_segs;
  bit [3:0] m_tn_hist;
  logic [NUM_CH-1:0] m_src = '0;
  logic [LEN_W-1:0] m_len = '0;

  function automatic bit f_comb(input logic [NUM_CH-1:0] tr, en, lv, input bit and_m,
                                output logic [NUM_CH-1:0] act);
    int n_en = 0, n_act = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      act[i] = en[i] && (tr[i] == lv[i]);
      n_en  += int'(en[i]);
      n_act += int'(act[i]);
    end
    return and_m ? (n_en > 0 && n_act == n_en) : (n_act > 0);
  endfunction

  always @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_wait_ready = 0; m_need_low = 0; m_started = 0; m_finished = 0;
      m_go = 0; m_comb_prev = 0; m_arm_prev = 0; m_cd = 0; m_segs = 0; m_tn_hist = '0;
      m_src = '0; m_len = '0;
    end else begin
      logic [NUM_CH-1:0] act;
      bit comb, tn, arm_rise;
      int goal;
      comb = f_comb(trigger_i, ch_enable_i, ch_level_i, combine_and_i, act);
      tn = m_tn_hist[2] & ~m_tn_hist[3];
      arm_rise = arm_i && !m_arm_prev;
      goal = (num_segments_i == 0) ? 1 : int'(num_segments_i);
      m_go = 0;
      if (!m_busy) begin
        if (arm_rise) begin m_busy = 1; m_wait_ready = 1; end
      end else if (!arm_i || capture_done_i) begin
        m_busy = 0; m_wait_ready = 0; m_need_low = 0; m_started = 0; m_finished = 0; m_cd = 0;
      end else if (m_wait_ready) begin
        if (armed_and_ready) begin m_wait_ready = 0; m_need_low = trigger_wait_i; end
      end else if (m_need_low) begin
        if (!comb) m_need_low = 0;
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          m_go = 1;
          m_segs++;
          if (m_segs >= goal) m_finished = 1;
        end
      end else if (m_finished) begin
        m_finished = 1;
      end else if (!m_started) begin
        if (comb || tn) begin m_started = 1; m_src = act; m_cd = int'(trigger_offset_i) + 1; end
      end else if (tn || (comb && !m_comb_prev)) begin
        m_cd = int'(trigger_offset_i) + 1;
      end
      if (arm_rise) begin m_segs = 0; m_len = '0; end
      else if (comb && m_len != '1) m_len = m_len + 1'b1;
      m_comb_prev = comb;
      m_arm_prev = arm_i;
      m_tn_hist = {m_tn_hist[2:0], trigger_now_i};
    end
  end

  always @(posedge adc_clk) begin
    #1;
    check("mdl_arm", arm_o, m_busy);
    check("mdl_active", capture_active_o, m_started);
    check("mdl_go", capture_go_o, m_go);
    check("mdl_seg", segment_cnt_o, SEG_W'(m_segs));
    check("mdl_src", trigger_source_o, m_src);
    check("mdl_len", trigger_length_o, m_len);
  end

  typedef struct {
    logic [NUM_CH-1:0] en, lv, tr;
    bit and_m, fire;
    logic [NUM_CH-1:0] src;
  } vec_t;
  vec_t vt[9];

  initial begin
    int gn, first;
    vt[0] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001};
    vt[1] = '{4'b0101, 4'b0000, 4'b1010, 1'b0, 1'b1, 4'b0101};
    vt[2] = '{4'b0110, 4'b0110, 4'b1001, 1'b0, 1'b0, 4'b0000};
    vt[3] = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000};
    vt[4] = '{4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000};
    vt[5] = '{4'b1100, 4'b1000, 4'b1000, 1'b1, 1'b1, 4'b1100};
    vt[6] = '{4'b1100, 4'b1000, 4'b1100, 1'b1, 1'b0, 4'b0000};
    vt[7] = '{4'b1011, 4'b1111, 4'b1011, 1'b1, 1'b1, 4'b1011};
    vt[8] = '{4'b1111, 4'b0101, 4'b0111, 1'b0, 1'b1, 4'b1101};

    trigger_i = '0; ch_enable_i = '0; ch_level_i = '0; combine_and_i = 0; trigger_wait_i = 0;
    trigger_now_i = 0; arm_i = 0; armed_and_ready = 1; trigger_offset_i = '0;
    num_segments_i = 16'd1; capture_done_i = 0;
    tick(3);
    check("rst_arm", arm_o, 0); check("rst_active", capture_active_o, 0);
    check("rst_go", capture_go_o, 0); check("rst_seg", segment_cnt_o, 0);
    check("rst_src", trigger_source_o, 0); check("rst_len", trigger_length_o, 0);
    reset_n = 1'b1;
    tick(2);

    for (int i = 0; i < 9; i++) begin
      ch_enable_i = vt[i].en; ch_level_i = vt[i].lv; combine_and_i = vt[i].and_m;
      trigger_i = vt[i].tr; trigger_offset_i = '0; num_segments_i = 16'd1;
      arm_i = 1'b1;
      tick(4);
      check($sformatf("vec%0d_fire", i), capture_active_o, vt[i].fire);
      if (vt[i].fire) check($sformatf("vec%0d_src", i), trigger_source_o, vt[i].src);
      settle();
    end

    // single segment, OR mode, offset 5
    ch_enable_i = 4'b0001; ch_level_i = 4'b0001; combine_and_i = 0; trigger_offset_i = 5;
    arm_i = 1; tick(1);
    check("s1_arm_o", arm_o, 1);
    tick(1);
    trigger_i = 4'b0001; tick(1);
    check("s1_active", capture_active_o, 1);
    run_count(20, gn, first);
    check("s1_go_at", first, 6); check("s1_go_n", gn, 1);
    check("s1_seg", segment_cnt_o, 1); check("s1_src", trigger_source_o, 4'b0001);
    check("s1_len", trigger_length_o, 21);
    capture_done_i = 1; tick(1); capture_done_i = 0;
    check("s1_done_arm", arm_o, 0); check("s1_done_active", capture_active_o, 0);
    settle();

    // AND mode
    ch_enable_i = 4'b0011; ch_level_i = 4'b0011; combine_and_i = 1; trigger_offset_i = 0;
    arm_i = 1; tick(2);
    trigger_i = 4'b0001; tick(10);
    check("and_partial", capture_active_o, 0);
    trigger_i = 4'b0011; tick(1);
    check("and_active", capture_active_o, 1);
    tick(1);
    check("and_go", capture_go_o, 1); check("and_src", trigger_source_o, 4'b0011);
    settle();

    // trigger_wait with ch0 already high at arm
    ch_enable_i = 4'b0001; ch_level_i = 4'b0001; combine_and_i = 0; trigger_wait_i = 1;
    trigger_i = 4'b0001; tick(3);
    arm_i = 1; tick(7);
    check("wait_held", capture_active_o, 0);
    trigger_i = 4'b0000; tick(3);
    trigger_i = 4'b0001;
    run_count(4, gn, first);
    check("wait_go_at", first, 2); check("wait_go_n", gn, 1);
    check("wait_len", trigger_length_o, 10);
    trigger_wait_i = 0;
    settle();

    // three segments, offset 0, fourth pulse ignored
    num_segments_i = 16'd3; trigger_offset_i = 0;
    arm_i = 1; tick(2);
    begin
      int total = 0;
      for (int p = 0; p < 4; p++) begin
        trigger_i = 4'b0001; run_count(4, gn, first); total += gn;
        trigger_i = 4'b0000; run_count(4, gn, first); total += gn;
      end
      check("seg_go_total", total, 3);
    end
    check("seg_cnt", segment_cnt_o, 3); check("seg_done_wait_arm", arm_o, 1);
    check("seg_done_wait_active", capture_active_o, 1);
    capture_done_i = 1; tick(1); capture_done_i = 0;
    check("seg_after_done_arm", arm_o, 0); check("seg_kept", segment_cnt_o, 3);
    num_segments_i = 16'd1;
    settle();

    // force trigger with all channels disabled
    ch_enable_i = '0; trigger_offset_i = 3;
    arm_i = 1; tick(2);
    trigger_now_i = 1;
    run_count(20, gn, first);
    check("tnow_go_at", first, 8); check("tnow_go_n", gn, 1);
    check("tnow_src", trigger_source_o, 0);
    settle();

    // abort mid-DELAY
    ch_enable_i = 4'b0001; trigger_offset_i = 100;
    arm_i = 1; tick(2);
    trigger_i = 4'b0001; tick(10);
    check("abort_pre_active", capture_active_o, 1);
    arm_i = 0; tick(1);
    check("abort_arm", arm_o, 0); check("abort_active", capture_active_o, 0);
    run_count(110, gn, first);
    check("abort_no_go", gn, 0);
    settle();

    // asynchronous reset mid-DELAY
    arm_i = 1; tick(2);
    trigger_i = 4'b0001; tick(5);
    check("areset_pre_active", capture_active_o, 1);
    #2 reset_n = 1'b0;
    #1;
    check("areset_arm", arm_o, 0); check("areset_active", capture_active_o, 0);
    check("areset_src", trigger_source_o, 0); check("areset_len", trigger_length_o, 0);
    arm_i = 0; trigger_i = '0;
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // randomized episodes against the model
    for (int e = 0; e < 40; e++) begin
      ch_enable_i = NUM_CH'($urandom_range(0, 15)); ch_level_i = NUM_CH'($urandom_range(0, 15));
      combine_and_i = 1'($urandom_range(0, 1)); trigger_wait_i = 1'($urandom_range(0, 1));
      trigger_offset_i = OFFSET_W'($urandom_range(0, 6));
      num_segments_i = SEG_W'($urandom_range(0, 3));
      trigger_i = NUM_CH'($urandom_range(0, 15));
      arm_i = 1;
      for (int c = 0; c < 60; c++) begin
        tick(1);
        trigger_i = trigger_i ^ NUM_CH'($urandom & $urandom);
        armed_and_ready = ($urandom_range(0, 3) != 0);
        capture_done_i = ($urandom_range(0, 49) == 0);
        trigger_now_i = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 79) == 0) arm_i = ~arm_i;
      end
      armed_and_ready = 1;
      settle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_unit_mc.md
# trigger_unit_mc

Multi-channel, segment-aware trigger unit for the ADC capture path. It qualifies NUM_CH trigger inputs, each with its own enable and polarity, and combines them in AND or OR mode. It then applies a programmable offset and issues one capture_go_o pulse per segment, re-arming between segments until the programmed segment count is reached. It sits between the trigger-source muxing and the ADC FIFO/segment controller, and reports trigger source, segment progress and trigger length to the register block.

## Interface
- NUM_CH, 4: number of trigger inputs (1..8)
- OFFSET_W, 32: width of trigger offset counter
- SEG_W, 16: width of segment count
- LEN_W, 32: width of trigger-length counter
- adc_clk  in  1  ADC sample clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- trigger_i  in  NUM_CH  raw trigger inputs, synchronous to adc_clk
- ch_enable_i  in  NUM_CH  per-channel enable
- ch_level_i  in  NUM_CH  per-channel active level (1 = high/rising, 0 = low/falling)
- combine_and_i  in  1  1 = all enabled channels active; 0 = any enabled channel active
- trigger_wait_i  in  1  1 = combined trigger must go inactive before arming completes
- trigger_now_i  in  1  asynchronous force-trigger; rising edge acts
- arm_i  in  1  arm request; rising edge arms, low aborts
- armed_and_ready  in  1  downstream FIFO ready to accept a capture
- trigger_offset_i  in  OFFSET_W  cycles from trigger to capture_go_o, reapplied per segment
- num_segments_i  in  SEG_W  segments per arm; 0 treated as 1
- capture_done_i  in  1  downstream capture complete
- arm_o  out  1  arm accepted, held until capture end or abort
- capture_active_o  out  1  first trigger seen, held until done or abort
- capture_go_o  out  1  one-cycle pulse per segment start
- segment_cnt_o  out  SEG_W  capture_go_o pulses issued since arm
- trigger_source_o  out  NUM_CH  active & enabled channels latched at the first trigger
- trigger_length_o  out  LEN_W  cycles the combined trigger was active since the last arm

## Operation
- Channel activity: act[i] = (trigger_i[i] == ch_level_i[i]) & ch_enable_i[i].
- OR mode: comb = |act.
- AND mode: comb = &(act | ~ch_enable_i) & |ch_enable_i.
- No channel enabled: comb = 0. trigger_now still works.
- trigger_now_i: two-flop synchroniser, then a rising-edge detect gives a one-cycle tnow. tnow is honoured only in ARMED and REARM.
- FSM states: IDLE, ARM_PEND, WAIT_INACT, ARMED, DELAY, REARM, DONE_WAIT.
- IDLE -> ARM_PEND on an arm_i rising edge. arm_o set.
- ARM_PEND -> WAIT_INACT when armed_and_ready=1 and trigger_wait_i=1; -> ARMED when armed_and_ready=1 and trigger_wait_i=0.
- WAIT_INACT -> ARMED when comb=0.
- ARMED -> DELAY on comb|tnow. Actions: capture_active_o set, trigger_source_o <= act, delay counter cleared.
- DELAY: counter increments each cycle. When counter == trigger_offset_i: capture_go_o pulses and segment_cnt_o increments. Then -> DONE_WAIT if segment_cnt_o+1 >= max(num_segments_i,1), else -> REARM.
- REARM: waits for comb=0, then a new comb edge or tnow -> DELAY. tnow bypasses the inactive wait.
- DONE_WAIT -> IDLE on capture_done_i.
- Global abort: from any non-IDLE state, -> IDLE when arm_i=0 or capture_done_i=1. Clears arm_o, capture_active_o and the delay counter. Keeps segment_cnt_o, trigger_source_o and trigger_length_o for readback.
- segment_cnt_o clears on the arm_i rising edge.
- trigger_length_o clears on the arm_i rising edge (clear wins over increment). Otherwise it increments every cycle comb=1, saturating at all-ones.
- Config inputs are sampled live. Software changes them only in IDLE.

## Timing
- Reset values: all outputs 0, FSM IDLE.
- comb first seen at edge k in ARMED:
  - capture_active_o high after edge k;
  - capture_go_o high for exactly the cycle after edge k+1+trigger_offset_i.
- Offset 0 gives a 2-cycle trigger-to-go latency.
- tnow latency from trigger_now_i: 2 synchroniser cycles plus 1 edge-detect cycle.
- REARM -> DELAY: comb first seen at edge m after an inactive cycle; capture_go_o after edge m+1+offset.
- capture_done_i and a trigger on the same edge: done wins. No go pulse is issued.
- arm_i low during DELAY: capture_go_o not issued.
- reset_n low mid-operation: all state cleared immediately, asynchronously.

## Structure
- Package trigger_pkg:
  - FSM state enum;
  - default parameter constants;
  - combine-mode encoding.
- Sub-module trigger_now_sync: two-flop synchroniser plus rising-edge pulse, clocked on adc_clk, reset_n async. Marked ASYNC_REG.
- Combine logic, FSM, counters and length counter stay in trigger_unit_mc.

## Test plan
- Single segment, OR mode:
  - Setup: ch_enable=0001, level=1, offset=5.
  - Stimulus: arm, raise ch0 at edge k.
  - Response: capture_active_o at k; one capture_go_o at k+6; segment_cnt_o=1; trigger_source_o=0001.
- AND mode:
  - Setup: enable=0011. Raise ch0 alone, then ch1 10 cycles later.
  - Response: no trigger until both are active. trigger_source_o=0011.
- trigger_wait_i=1 with ch0 already active at arm:
  - Response: no go until ch0 drops and rises again.
  - trigger_length_o counts the initial high period plus the second high period.
- Segments:
  - Setup: num_segments=3, offset=0. Pulse ch0 three times, each 4 cycles high and 4 low.
  - Response: three go pulses; segment_cnt_o=3; DONE_WAIT until capture_done_i; a fourth pulse is ignored.
- trigger_now_i:
  - Stimulus: assert trigger_now_i with all channels disabled.
  - Response: go pulse follows after sync latency plus offset.
- Abort:
  - Stimulus: drop arm_i mid-DELAY (offset=100).
  - Response: no go pulse; arm_o=0, capture_active_o=0 next cycle.
- Async reset:
  - Stimulus: assert reset_n mid-DELAY.
  - Response: all outputs 0 before the next edge.
